// File: rtl/loader_pkg.sv
// Shared types and helpers for the parameter loader family.
package loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int DEFAULT_DATA_W = 16;

   // Index width with a floor of one bit so single-entry dimensions still get a port.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/loader_addr_gen.sv
// Row-major row/col walker: clear, increment, and a flag marking the final element.
module loader_addr_gen
   import loader_pkg::*;
#(
   parameter  int ROWS  = 2,
   parameter  int COLS  = 4,
   localparam int ROW_W = idx_w(ROWS),
   localparam int COL_W = idx_w(COLS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic             last
);

   logic col_end;

   assign col_end = (col == COL_W'(COLS - 1));
   assign last    = col_end && (row == ROW_W'(ROWS - 1));

   // Wraps to (0,0) after the final element so the next burst starts clean.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row <= '0;
         col <= '0;
      end else if (clr) begin
         row <= '0;
         col <= '0;
      end else if (inc) begin
         if (col_end) begin
            col <= '0;
            row <= last ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/param_loader.sv
// ROWS x COLS parameter store, filled by host writes or a row-major stream burst.
// Optional stream checksum built only when PARAM_LOADER_CHECKSUM_EN is defined.
//
// state  | meaning
// IDLE   | no burst since reset; host writes accepted
// STREAM | burst in flight; s_ready high, host writes dropped
// DONE   | burst complete; done high until next start
module param_loader
   import loader_pkg::*;
#(
   parameter  int ROWS   = 2,
   parameter  int COLS   = 4,
   parameter  int DATA_W = DEFAULT_DATA_W,
   localparam int ROW_W  = idx_w(ROWS),
   localparam int COL_W  = idx_w(COLS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              write,
   input  logic [ROW_W-1:0]  seli,
   input  logic [COL_W-1:0]  selj,
   input  logic [DATA_W-1:0] param_in,
   input  logic              start,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   input  logic              rd_en,
   input  logic [ROW_W-1:0]  rd_row,
   input  logic [COL_W-1:0]  rd_col,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum
);

   state_t            state, state_nxt;
   logic              clr, beat, last;
   logic [ROW_W-1:0]  row;
   logic [COL_W-1:0]  col;
   logic              wr_row_ok, wr_col_ok, rd_row_ok, rd_col_ok;
   logic [DATA_W-1:0] mem [ROWS][COLS];

   assign busy    = (state == STREAM);
   assign s_ready = busy;
   assign done    = (state == DONE);
   assign beat    = busy && s_valid;

   loader_addr_gen #(.ROWS(ROWS), .COLS(COLS)) u_addr (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .inc     (beat),
      .row     (row),
      .col     (col),
      .last    (last)
   );

   // A power-of-two dimension cannot be addressed out of range.
   generate
      if (ROWS == (1 << ROW_W)) begin : g_row_full
         assign wr_row_ok = 1'b1;
         assign rd_row_ok = 1'b1;
      end else begin : g_row_part
         assign wr_row_ok = (seli < ROW_W'(ROWS));
         assign rd_row_ok = (rd_row < ROW_W'(ROWS));
      end
      if (COLS == (1 << COL_W)) begin : g_col_full
         assign wr_col_ok = 1'b1;
         assign rd_col_ok = 1'b1;
      end else begin : g_col_part
         assign wr_col_ok = (selj < COL_W'(COLS));
         assign rd_col_ok = (rd_col < COL_W'(COLS));
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = STREAM;
               clr       = 1'b1;
            end
         end
         STREAM: begin
            if (beat && last) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               mem[r][c] <= '0;
      end else if (beat) begin
         mem[row][col] <= s_data;
      end else if (write && !busy && wr_row_ok && wr_col_ok) begin
         mem[seli][selj] <= param_in;
      end
   end

   // Reads see the array before this cycle's write lands.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_data <= (rd_row_ok && rd_col_ok) ? mem[rd_row][rd_col] : '0;
      end
   end

`ifdef PARAM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  sum_q <= '0;
      else if (clr)  sum_q <= '0;
      else if (beat) sum_q <= sum_q + s_data;
   end

   assign checksum = sum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_param_loader.sv
// Directed scoreboard bench for param_loader: default 2x4 instance plus a 3x3 instance for range checks.
module tb_param_loader;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, write, start, s_valid, rd_en;
   logic [0:0]  seli, rd_row;
   logic [1:0]  selj, rd_col;
   logic [15:0] param_in, s_data, rd_data, checksum;
   logic        s_ready, rd_valid, busy, done;

   logic        write2, rd_en2;
   logic [1:0]  seli2, selj2, rd_row2, rd_col2;
   logic [15:0] rd_data2, checksum2;
   logic        s_ready2, rd_valid2, busy2, done2;

   logic [15:0] m  [2][4];
   logic [15:0] m2 [3][3];
   logic [15:0] q[$];
   logic [15:0] q2[$];
   logic [15:0] csum;
   int          checks = 0;
   int          errors = 0;

   param_loader #(.ROWS(2), .COLS(4), .DATA_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .write(write), .seli(seli), .selj(selj),
      .param_in(param_in), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
      .checksum(checksum)
   );

   param_loader #(.ROWS(3), .COLS(3), .DATA_W(16)) dut2 (
      .clk(clk), .reset_n(reset_n), .write(write2), .seli(seli2), .selj(selj2),
      .param_in(param_in), .start(1'b0), .s_valid(1'b0), .s_data(16'h0000),
      .s_ready(s_ready2), .rd_en(rd_en2), .rd_row(rd_row2), .rd_col(rd_col2),
      .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2), .done(done2),
      .checksum(checksum2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, clear one-shot strobes, score any read that was due.
   task automatic tick();
      @(posedge clk);
      #1;
      rd_en = 1'b0; write = 1'b0; start = 1'b0; rd_en2 = 1'b0; write2 = 1'b0;
      chk("rd_valid", rd_valid, q.size() > 0);
      if (q.size() > 0) chk("rd_data", rd_data, q.pop_front());
      chk("rd_valid2", rd_valid2, q2.size() > 0);
      if (q2.size() > 0) chk("rd_data2", rd_data2, q2.pop_front());
   endtask

   task automatic rd(input int r, input int c);
      rd_en = 1'b1; rd_row = r[0:0]; rd_col = c[1:0];
      q.push_back(m[r][c]);
   endtask

   task automatic wr(input int r, input int c, input logic [15:0] d, input bit apply);
      write = 1'b1; seli = r[0:0]; selj = c[1:0]; param_in = d;
      if (apply) m[r][c] = d;
   endtask

   task automatic rd2(input int r, input int c);
      rd_en2 = 1'b1; rd_row2 = r[1:0]; rd_col2 = c[1:0];
      if (r < 3 && c < 3) q2.push_back(m2[r][c]);
      else                q2.push_back(16'h0000);
   endtask

   task automatic wr2(input int r, input int c, input logic [15:0] d);
      write2 = 1'b1; seli2 = r[1:0]; selj2 = c[1:0]; param_in = d;
      if (r < 3 && c < 3) m2[r][c] = d;
   endtask

   task automatic read_all();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) begin
            rd(r, c);
            tick();
         end
      tick();
   endtask

   task automatic clear_model();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) m[r][c] = 16'h0000;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) m2[r][c] = 16'h0000;
   endtask

   function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef PARAM_LOADER_CHECKSUM_EN
      return s;
`else
      return 16'h0000;
`endif
   endfunction

   initial begin
      reset_n = 1'b0; write = 1'b0; start = 1'b0; s_valid = 1'b0; rd_en = 1'b0;
      seli = '0; selj = '0; rd_row = '0; rd_col = '0; param_in = '0; s_data = '0;
      write2 = 1'b0; rd_en2 = 1'b0; seli2 = '0; selj2 = '0; rd_row2 = '0; rd_col2 = '0;
      csum = '0;
      clear_model();

      tick();
      tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rd_data", rd_data, 16'h0000);
      chk("rst_checksum", checksum, 16'h0000);
      chk("rst_dut2_flags", {s_ready2, busy2, done2}, 3'b000);
      chk("rst_dut2_checksum", checksum2, 16'h0000);
      reset_n = 1'b1;
      tick();

      read_all();

      wr(1, 3, 16'hABCD, 1);
      tick();
      rd(1, 3);
      tick();
      tick();

      start = 1'b1;
      tick();
      chk("busy_after_start", busy, 1'b1);
      chk("s_ready_after_start", s_ready, 1'b1);
      chk("done_after_start", done, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         s_valid = 1'b1;
         s_data  = 16'(k);
         m[(k - 1) / 4][(k - 1) % 4] = 16'(k);
         csum = csum + 16'(k);
         tick();
         s_valid = 1'b0;
         if (k == 7) begin
            chk("done_before_last", done, 1'b0);
            chk("busy_before_last", busy, 1'b1);
         end
         if (k == 8) begin
            chk("done_after_last", done, 1'b1);
            chk("busy_after_last", busy, 1'b0);
            chk("s_ready_after_last", s_ready, 1'b0);
         end
         if (k == 1) rd(0, 0);
         if (k == 2) begin
            wr(0, 0, 16'hFFFF, 0);
            start = 1'b1;
         end
         tick();
      end
      chk("checksum_burst", checksum, exp_sum(csum));
      read_all();
      chk("done_sticky", done, 1'b1);

      rd(0, 1);
      wr(0, 1, 16'h1234, 1);
      tick();
      rd(0, 1);
      tick();
      tick();
      chk("checksum_after_host_write", checksum, exp_sum(csum));

      start = 1'b1;
      tick();
      chk("done_cleared_on_start", done, 1'b0);
      chk("checksum_cleared_on_start", checksum, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         s_valid = 1'b1;
         s_data  = 16'h0011 + 16'(k);
         tick();
      end
      s_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_s_ready", s_ready, 1'b0);
      chk("midrst_checksum", checksum, 16'h0000);
      clear_model();
      tick();
      reset_n = 1'b1;
      tick();
      read_all();

      start = 1'b1;
      tick();
      s_valid = 1'b1;
      s_data  = 16'h0099;
      m[0][0] = 16'h0099;
      tick();
      s_valid = 1'b0;
      rd(0, 0);
      tick();
      rd(0, 1);
      tick();
      chk("restream_checksum", checksum, exp_sum(16'h0099));
      tick();

      wr2(3, 0, 16'h0077);
      tick();
      wr2(0, 3, 16'h0066);
      tick();
      wr2(3, 3, 16'h0088);
      tick();
      wr2(2, 2, 16'h0055);
      tick();
      rd2(2, 2); tick();
      rd2(3, 0); tick();
      rd2(0, 3); tick();
      rd2(3, 3); tick();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            rd2(r, c);
            tick();
         end
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
